ex_muldiv: RTL

Multi-cycle multiply/divide sequencer in the EX stage, alongside the single-cycle ALU. Owns the architectural HI/LO registers. Runs MULT/MULTU with a fixed-latency multiplier and DIV/DIVU with an iterative radix-2 restoring divider, and stalls the pipeline while an operation is in flight. Also services MTHI/MTLO writes, and aborts on pipeline flush (exception or branch squash).

---
 rtl/ex_muldiv_if.sv | 23 ++
 rtl/ex_muldiv.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_if.sv
// ex_muldiv_if: EX-stage mul/div request and HI/LO result bundle.
// master = pipeline (valid, md_op, src_a, src_b, flush); slave = unit (stall, done, hi, lo).
interface ex_muldiv_if;
  logic        valid;
  logic [2:0]  md_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        stall;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output valid, md_op, src_a, src_b, flush,
    input  stall, done, hi, lo
  );

  modport slave (
    input  valid, md_op, src_a, src_b, flush,
    output stall, done, hi, lo
  );
endinterface

// File: rtl/ex_muldiv.sv
// ex_muldiv: HI/LO owner; fixed-latency MULT/MULTU, radix-2 restoring DIV/DIVU.
// Ports: clk, rst (sync, active-high), md (ex_muldiv_if.slave).
module ex_muldiv #(
  parameter int MUL_CYCLES = 3,
  parameter int DIV_CYCLES = 32
) (
  input logic      clk,
  input logic      rst,
  ex_muldiv_if.slave md
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam logic [4:0] MUL_INIT = 5'(MUL_CYCLES - 1);
  localparam logic [4:0] DIV_INIT = 5'(DIV_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [4:0]  cnt_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] rem_q;
  logic        sgn_q;
  logic        nq_q;
  logic        nr_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  logic        is_mul;
  logic        is_div;
  logic        sdiv;
  logic        issue;
  logic        start_mul;
  logic        start_div;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [63:0] ext_a;
  logic [63:0] ext_b;
  logic [63:0] prod;
  logic [32:0] r_sh;
  logic [32:0] diff;
  logic        no_borrow;
  logic [31:0] rem_n;
  logic [31:0] quo_n;
  logic [31:0] q_fix;
  logic [31:0] r_fix;

  assign is_mul = (md.md_op == OP_MULT)
                | (md.md_op == OP_MULTU);
  assign is_div = (md.md_op == OP_DIV)
                | (md.md_op == OP_DIVU);
  assign sdiv   = (md.md_op == OP_DIV);

  assign issue = (state_q == S_IDLE)
               & md.valid & ~md.flush;
  assign start_mul = issue & is_mul;
  assign start_div = issue & is_div
                   & (md.src_b != 32'd0);

  // |0x80000000| wraps to itself, read as unsigned
  assign abs_a = (sdiv & md.src_a[31])
               ? -md.src_a : md.src_a;
  assign abs_b = (sdiv & md.src_b[31])
               ? -md.src_b : md.src_b;

  // low 64 bits of the extended product are exact
  // for both signed and unsigned operands
  assign ext_a = {{32{sgn_q & a_q[31]}}, a_q};
  assign ext_b = {{32{sgn_q & b_q[31]}}, b_q};
  assign prod  = ext_a * ext_b;

  // a_q shifts the dividend out and quotient bits in
  assign r_sh      = {rem_q, a_q[31]};
  assign diff      = r_sh - {1'b0, b_q};
  assign no_borrow = ~diff[32];
  assign rem_n     = no_borrow ? diff[31:0]
                               : r_sh[31:0];
  assign quo_n     = {a_q[30:0], no_borrow};
  assign q_fix     = nq_q ? -quo_n : quo_n;
  assign r_fix     = nr_q ? -rem_n : rem_n;

  always_comb begin
    state_d  = state_q;
    md.stall = 1'b0;
    md.done  = 1'b0;
    if (md.flush) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start_mul) begin
            state_d  = S_MUL;
            md.stall = 1'b1;
          end else if (start_div) begin
            state_d  = S_DIV;
            md.stall = 1'b1;
          end
        end
        S_MUL, S_DIV: begin
          md.stall = 1'b1;
          if (cnt_q == 5'd0) begin
            md.done = 1'b1;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 5'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      rem_q   <= 32'd0;
      sgn_q   <= 1'b0;
      nq_q    <= 1'b0;
      nr_q    <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      if (!md.flush) begin
        if (issue & (md.md_op == OP_MTHI))
          hi_q <= md.src_a;
        if (issue & (md.md_op == OP_MTLO))
          lo_q <= md.src_a;
        if (start_mul) begin
          a_q   <= md.src_a;
          b_q   <= md.src_b;
          sgn_q <= (md.md_op == OP_MULT);
          cnt_q <= MUL_INIT;
        end
        if (start_div) begin
          a_q   <= abs_a;
          b_q   <= abs_b;
          rem_q <= 32'd0;
          nq_q  <= sdiv
                 & (md.src_a[31] ^ md.src_b[31]);
          nr_q  <= sdiv & md.src_a[31];
          cnt_q <= DIV_INIT;
        end
        if (state_q == S_MUL) begin
          if (cnt_q == 5'd0) begin
            {hi_q, lo_q} <= prod;
          end else begin
            cnt_q <= cnt_q - 5'd1;
          end
        end
        if (state_q == S_DIV) begin
          a_q   <= quo_n;
          rem_q <= rem_n;
          if (cnt_q == 5'd0) begin
            lo_q <= q_fix;
            hi_q <= r_fix;
          end else begin
            cnt_q <= cnt_q - 5'd1;
          end
        end
      end
    end
  end

  assign md.hi = hi_q;
  assign md.lo = lo_q;

endmodule
